// File: rtl/clken_mux_n.sv
// clken_mux_n: N-way glitch-free clock-enable selector for one clock domain.
// Chooses one of N enable streams derived from clk and forwards it to
// downstream clock gates. Switching is break-before-make: the old pulse is
// allowed to finish, a programmable gap of forced-low cycles follows, and the
// new source is only connected once it is low, so its first visible pulse is
// complete. A one-cycle request/acknowledge handshake reports completion, and
// test_mode forces the enable high without disturbing the switch sequence.

module clken_mux_n #(
  parameter int N         = 4,
  parameter int RESET_SEL = 0,
  parameter int GAP_CYC   = 2,
  parameter int WAIT_MAX  = 64,
  parameter int SELW      = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    clk_en_in,
  input  logic [SELW-1:0] sel,
  input  logic            sel_req,
  input  logic            test_mode,
  output logic            clk_en_out,
  output logic            sel_ack,
  output logic            sel_err,
  output logic            busy,
  output logic [SELW-1:0] cur_sel
);

  // The counter is shared by the gap timer and the drain/arm timeout, so it
  // must hold the larger of the two limits.
  localparam int CNT_MAX = (GAP_CYC > WAIT_MAX) ? GAP_CYC : WAIT_MAX;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  // The enable vector is padded to a power of two so that any SELW-bit index
  // lands on a defined bit, even when N is not a power of two.
  localparam int EXTW = 2 ** SELW;

  localparam logic [CNTW-1:0] WAIT_LAST   = CNTW'(WAIT_MAX - 1);
  localparam logic [CNTW-1:0] GAP_LAST    = CNTW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [SELW-1:0] RESET_SEL_V = SELW'(RESET_SEL);
  localparam logic [SELW:0]   N_V         = (SELW + 1)'(N);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GAP   = 2'd2,
    ST_ARM   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SELW-1:0] cur_q, cur_d;
  logic [SELW-1:0] nxt_q, nxt_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  logic [EXTW-1:0] en_ext;
  logic            cur_en;
  logic            nxt_en;
  logic            sel_in_range;
  logic            wait_expired;
  logic            gap_done;

  // Zero-extend the source vector and pick out the current and pending sources.
  always_comb begin
    en_ext       = EXTW'(clk_en_in);
    cur_en       = en_ext[cur_q];
    nxt_en       = en_ext[nxt_q];
    sel_in_range = ({1'b0, sel} < N_V);
    wait_expired = (cnt_q == WAIT_LAST);
    gap_done     = (cnt_q == GAP_LAST);
  end

  // Next-state logic: request decode in RUN, then drain, gap and arm phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (sel_req) begin
          if (!sel_in_range) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else if (sel == cur_q) begin
            ack_d = 1'b1;
          end else begin
            nxt_d   = sel;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (!cur_en || wait_expired) begin
          cnt_d   = '0;
          state_d = (GAP_CYC > 0) ? ST_GAP : ST_ARM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_done) begin
          cnt_d   = '0;
          state_d = ST_ARM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_ARM: begin
        if (!nxt_en || wait_expired) begin
          cnt_d   = '0;
          cur_d   = nxt_q;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_RUN;
      end
    endcase
  end

  // State and handshake registers; reset abandons any switch in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      cur_q   <= RESET_SEL_V;
      nxt_q   <= RESET_SEL_V;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Only RUN and DRAIN pass the selected source through; test_mode overrides.
  always_comb begin
    clk_en_out = test_mode | (((state_q == ST_RUN) || (state_q == ST_DRAIN)) & cur_en);
  end

  assign sel_ack = ack_q;
  assign sel_err = err_q;
  assign busy    = busy_q;
  assign cur_sel = cur_q;

endmodule

// File: tb/tb_clken_mux_n.sv
// tb_clken_mux_n: directed and randomized checks of clken_mux_n against a
// cycle-level behavioural reference that follows the switch rules directly.

module tb_clken_mux_n;

  localparam int N         = 6;
  localparam int RESET_SEL = 0;
  localparam int GAP_CYC   = 2;
  localparam int WAIT_MAX  = 8;
  localparam int SELW      = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    clk_en_in;
  logic [SELW-1:0] sel;
  logic            sel_req;
  logic            test_mode;
  logic            clk_en_out;
  logic            sel_ack;
  logic            sel_err;
  logic            busy;
  logic [SELW-1:0] cur_sel;

  clken_mux_n #(
    .N(N),
    .RESET_SEL(RESET_SEL),
    .GAP_CYC(GAP_CYC),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_en_in(clk_en_in),
    .sel(sel),
    .sel_req(sel_req),
    .test_mode(test_mode),
    .clk_en_out(clk_en_out),
    .sel_ack(sel_ack),
    .sel_err(sel_err),
    .busy(busy),
    .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  // Each source is a periodic stream: high for hi cycles out of per, shifted by ph.
  int per [N];
  int hi  [N];
  int ph  [N];

  int cycle_no  = 0;
  int checks    = 0;
  int passes    = 0;
  int ack_seen  = 0;

  // Reference: which step of a switch is underway and how long it has lasted.
  // step 0 = idle on m_cur, 1 = old pulse finishing, 2 = forced gap, 3 = waiting for new source low.
  int m_step;
  int m_cur;
  int m_tgt;
  int m_time;
  bit m_busy;
  bit m_ack;
  bit m_err;

  function automatic logic [N-1:0] sources(input int c);
    logic [N-1:0] s;
    for (int i = 0; i < N; i++) s[i] = (((c + ph[i]) % per[i]) < hi[i]);
    return s;
  endfunction

  task automatic setSource(input int i, input int p, input int h, input int f);
    per[i] = p;
    hi[i]  = h;
    ph[i]  = f;
  endtask

  task automatic randomizePatterns();
    for (int i = 0; i < N; i++) begin
      per[i] = $urandom_range(1, 6);
      hi[i]  = $urandom_range(0, per[i]);
      ph[i]  = $urandom_range(0, 5);
    end
  endtask

  task automatic modelReset();
    m_step = 0;
    m_cur  = RESET_SEL;
    m_tgt  = RESET_SEL;
    m_time = 0;
    m_busy = 1'b0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
  endtask

  // Advance the reference by one clock edge using the inputs held during that cycle.
  task automatic modelEdge(input bit rst, input bit req, input int s, input logic [N-1:0] en);
    if (rst) begin
      modelReset();
      return;
    end
    m_ack = 1'b0;
    m_err = 1'b0;
    if (m_step == 0) begin
      if (req) begin
        if (s >= N) begin
          m_ack = 1'b1;
          m_err = 1'b1;
        end else if (s == m_cur) begin
          m_ack = 1'b1;
        end else begin
          m_tgt  = s;
          m_step = 1;
          m_time = 0;
          m_busy = 1'b1;
        end
      end
    end else if (m_step == 1) begin
      if (!en[m_cur] || m_time + 1 >= WAIT_MAX) begin
        m_step = (GAP_CYC > 0) ? 2 : 3;
        m_time = 0;
      end else m_time++;
    end else if (m_step == 2) begin
      if (m_time + 1 >= GAP_CYC) begin
        m_step = 3;
        m_time = 0;
      end else m_time++;
    end else begin
      if (!en[m_tgt] || m_time + 1 >= WAIT_MAX) begin
        m_cur  = m_tgt;
        m_busy = 1'b0;
        m_ack  = 1'b1;
        m_step = 0;
        m_time = 0;
      end else m_time++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle_no);
  endtask

  // Drive one cycle of inputs, compare every output mid-cycle, then step the reference.
  task automatic applyStimulus(input bit rst, input bit req, input int s, input bit tm);
    logic exp_out;
    reset     = rst;
    sel_req   = req;
    sel       = SELW'(s);
    test_mode = tm;
    clk_en_in = sources(cycle_no);
    @(negedge clk);
    exp_out = tm | ((m_step <= 1) && clk_en_in[m_cur]);
    checkOutput("clk_en_out", {31'd0, clk_en_out}, {31'd0, exp_out});
    checkOutput("busy",       {31'd0, busy},       {31'd0, m_busy});
    checkOutput("sel_ack",    {31'd0, sel_ack},    {31'd0, m_ack});
    checkOutput("sel_err",    {31'd0, sel_err},    {31'd0, m_err});
    checkOutput("cur_sel",    32'(cur_sel),        32'(m_cur));
    if (sel_ack === 1'b1) ack_seen++;
    @(posedge clk);
    modelEdge(rst, req, s, clk_en_in);
    cycle_no++;
    #1;
  endtask

  task automatic idle(input int n, input bit tm);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, tm);
  endtask

  // Idle until the given source is high, bounded so the bench cannot stall.
  task automatic waitSourceHigh(input int i);
    int k;
    k = 0;
    while (k < 20 && !sources(cycle_no)[i]) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      k++;
    end
  endtask

  initial begin
    int acks0;
    int k;

    for (int i = 0; i < N; i++) setSource(i, 3, 1, i);
    setSource(0, 2, 1, 0);
    reset     = 1'b1;
    sel_req   = 1'b0;
    sel       = '0;
    test_mode = 1'b0;
    clk_en_in = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    $display("[TB] reset state with source 0 toggling");
    idle(6, 1'b0);

    $display("[TB] mid-pulse switch from 1-of-4 source to 2-high/2-low source");
    setSource(0, 4, 1, 0);
    setSource(2, 4, 2, 1);
    waitSourceHigh(0);
    acks0 = ack_seen;
    applyStimulus(1'b0, 1'b1, 2, 1'b0);
    idle(16, 1'b0);
    checkOutput("switch_ack_count", 32'(ack_seen - acks0), 32'd1);
    checkOutput("switch_cur_sel", 32'(cur_sel), 32'd2);

    $display("[TB] out-of-range and same-source requests");
    acks0 = ack_seen;
    applyStimulus(1'b0, 1'b1, 6, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 7, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 2, 1'b0);
    idle(2, 1'b0);
    checkOutput("short_ack_count", 32'(ack_seen - acks0), 32'd3);

    $display("[TB] constant-high target forces arm timeout");
    setSource(3, 1, 1, 0);
    applyStimulus(1'b0, 1'b1, 3, 1'b0);
    idle(2 * WAIT_MAX + GAP_CYC + 6, 1'b0);
    checkOutput("const_cur_sel", 32'(cur_sel), 32'd3);
    checkOutput("const_out_high", {31'd0, clk_en_out}, 32'd1);

    $display("[TB] second request while busy is ignored");
    acks0 = ack_seen;
    applyStimulus(1'b0, 1'b1, 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4, 1'b0);
    applyStimulus(1'b0, 1'b1, 5, 1'b0);
    idle(2 * WAIT_MAX + GAP_CYC + 4, 1'b0);
    checkOutput("busy_ack_count", 32'(ack_seen - acks0), 32'd1);
    checkOutput("busy_cur_sel", 32'(cur_sel), 32'd1);

    $display("[TB] reset during gap aborts switch");
    setSource(1, 2, 1, 0);
    applyStimulus(1'b0, 1'b1, 4, 1'b0);
    k = 0;
    while (k < 2 * WAIT_MAX && m_step != 2) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      k++;
    end
    checkOutput("gap_busy", {31'd0, busy}, 32'd1);
    acks0 = ack_seen;
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    idle(2 * WAIT_MAX, 1'b0);
    checkOutput("reset_no_ack", 32'(ack_seen - acks0), 32'd0);
    checkOutput("reset_cur_sel", 32'(cur_sel), 32'(RESET_SEL));

    $display("[TB] test_mode held through a switch");
    acks0 = ack_seen;
    applyStimulus(1'b0, 1'b1, 2, 1'b1);
    idle(2 * WAIT_MAX + GAP_CYC + 4, 1'b1);
    checkOutput("tm_ack_count", 32'(ack_seen - acks0), 32'd1);
    checkOutput("tm_cur_sel", 32'(cur_sel), 32'd2);

    $display("[TB] randomized traffic");
    for (int blk = 0; blk < 8; blk++) begin
      randomizePatterns();
      for (int c = 0; c < 200; c++) begin
        applyStimulus(($urandom_range(0, 199) == 0),
                      ($urandom_range(0, 5) == 0),
                      int'($urandom_range(0, 7)),
                      ($urandom_range(0, 9) == 0));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
